// File: rtl/overvoltage_seq.sv
// -----------------------------------------------------------------------------
// overvoltage_seq
//
// Power-up, settle and monitor sequencer for an analog overvoltage detector.
// The detector is enabled, allowed to settle for SETTLE_CYCLES, then its
// comparator output is debounced for DEBOUNCE_CYCLES consecutive samples
// before a trip is declared. A trip sets a sticky flag and fires a one-cycle
// interrupt. A new trip code restarts the settle period.
//
// Ports
//   clk        in   block clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   level request to power and monitor the detector
//   otrip_req  in   [3:0] requested trip code, taken on cfg_load
//   cfg_load   in   one-cycle strobe applying otrip_req
//   ovout      in   raw comparator output, asynchronous to clk
//   clr        in   one-cycle strobe clearing the sticky flag
//   otrip      out  [3:0] applied trip code for the 4-to-16 trip decoder
//   ana_ena    out  analog detector enable
//   ready      out  high while monitoring
//   ov_flag    out  sticky overvoltage status
//   ov_irq     out  one-cycle pulse per new trip
// -----------------------------------------------------------------------------
module overvoltage_seq #(
   parameter int SETTLE_CYCLES   = 64,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [3:0] otrip_req,
   input  logic       cfg_load,
   input  logic       ovout,
   input  logic       clr,
   output logic [3:0] otrip,
   output logic       ana_ena,
   output logic       ready,
   output logic       ov_flag,
   output logic       ov_irq
);

   localparam logic [9:0] SETTLE_LOAD = 10'(SETTLE_CYCLES);
   localparam logic [7:0] DEB_MAX     = 8'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_SETTLE,
      ST_MONITOR,
      ST_TRIPPED
   } state_t;

   state_t     state_q, state_d;
   logic [9:0] settle_cnt_q, settle_cnt_d;
   logic [7:0] deb_cnt_q, deb_cnt_d;
   logic       sync1_q, sync1_d;
   logic       ov_s_q, ov_s_d;
   logic [3:0] otrip_q, otrip_d;
   logic       ana_ena_q, ana_ena_d;
   logic       ready_q, ready_d;
   logic       ov_flag_q, ov_flag_d;
   logic       ov_irq_q, ov_irq_d;
   logic       trip;

   // Next-state and next-output logic. Priority: ena=0, cfg_load, trip, clr.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      deb_cnt_d    = deb_cnt_q;
      trip         = 1'b0;
      sync1_d      = ovout;
      ov_s_d       = sync1_q;
      otrip_d      = cfg_load ? otrip_req : otrip_q;

      if (!ena) begin
         state_d      = ST_OFF;
         settle_cnt_d = '0;
         deb_cnt_d    = '0;
      end else if (cfg_load || state_q == ST_OFF) begin
         // Enable from OFF and any reconfiguration both restart settling.
         state_d      = ST_SETTLE;
         settle_cnt_d = SETTLE_LOAD;
         deb_cnt_d    = '0;
      end else begin
         unique case (state_q)
            ST_SETTLE: begin
               deb_cnt_d = '0;
               // Counter reaching zero on this edge hands over to MONITOR.
               if (settle_cnt_q <= 10'd1) begin
                  settle_cnt_d = '0;
                  state_d      = ST_MONITOR;
               end else begin
                  settle_cnt_d = settle_cnt_q - 10'd1;
               end
            end
            ST_MONITOR: begin
               if (ov_s_q) begin
                  if (deb_cnt_q >= DEB_MAX - 8'd1) begin
                     deb_cnt_d = DEB_MAX;
                     state_d   = ST_TRIPPED;
                     trip      = 1'b1;
                  end else begin
                     deb_cnt_d = deb_cnt_q + 8'd1;
                  end
               end else begin
                  deb_cnt_d = '0;
               end
            end
            ST_TRIPPED: begin
               if (clr && !ov_s_q) begin
                  state_d   = ST_MONITOR;
                  deb_cnt_d = '0;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end

      // A set wins over a clear; a clear is refused while still tripped
      // with the comparator high.
      ov_flag_d = ov_flag_q;
      if (trip) begin
         ov_flag_d = 1'b1;
      end else if (clr && !(state_q == ST_TRIPPED && ov_s_q)) begin
         ov_flag_d = 1'b0;
      end

      // Outputs are decoded from the next state so they leave a flop.
      ana_ena_d = (state_d != ST_OFF);
      ready_d   = (state_d == ST_MONITOR);
      ov_irq_d  = trip;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_OFF;
         settle_cnt_q <= '0;
         deb_cnt_q    <= '0;
         sync1_q      <= 1'b0;
         ov_s_q       <= 1'b0;
         otrip_q      <= '0;
         ana_ena_q    <= 1'b0;
         ready_q      <= 1'b0;
         ov_flag_q    <= 1'b0;
         ov_irq_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         deb_cnt_q    <= deb_cnt_d;
         sync1_q      <= sync1_d;
         ov_s_q       <= ov_s_d;
         otrip_q      <= otrip_d;
         ana_ena_q    <= ana_ena_d;
         ready_q      <= ready_d;
         ov_flag_q    <= ov_flag_d;
         ov_irq_q     <= ov_irq_d;
      end
   end

   assign otrip   = otrip_q;
   assign ana_ena = ana_ena_q;
   assign ready   = ready_q;
   assign ov_flag = ov_flag_q;
   assign ov_irq  = ov_irq_q;

endmodule

// File: tb/tb_overvoltage_seq.sv
// -----------------------------------------------------------------------------
// tb_overvoltage_seq
//
// Bench for overvoltage_seq with default parameters. A behavioural model
// tracks power, remaining settle time, the current run of high comparator
// samples and the trip/flag status; a compare process checks every output
// against it after each clock edge. Directed scenarios pin the model with
// hand-computed literals, then randomized stimulus exercises the rest.
// -----------------------------------------------------------------------------
module tb_overvoltage_seq;

   localparam int SETTLE   = 64;
   localparam int DEBOUNCE = 8;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [3:0] otrip_req;
   logic       cfg_load;
   logic       ovout;
   logic       clr;
   logic [3:0] otrip;
   logic       ana_ena;
   logic       ready;
   logic       ov_flag;
   logic       ov_irq;

   int n_checks = 0;
   int n_fail   = 0;

   overvoltage_seq #(
      .SETTLE_CYCLES  (SETTLE),
      .DEBOUNCE_CYCLES(DEBOUNCE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .otrip_req(otrip_req),
      .cfg_load (cfg_load),
      .ovout    (ovout),
      .clr      (clr),
      .otrip    (otrip),
      .ana_ena  (ana_ena),
      .ready    (ready),
      .ov_flag  (ov_flag),
      .ov_irq   (ov_irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   bit         m_powered;
   bit         m_tripped;
   bit         m_flag;
   bit         m_irq;
   int         m_settle_left;
   int         m_streak;
   logic [3:0] m_otrip;
   bit         ov_hist[$];   // comparator samples still in flight to the FSM

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_powered     = 1'b0;
         m_tripped     = 1'b0;
         m_flag        = 1'b0;
         m_irq         = 1'b0;
         m_settle_left = 0;
         m_streak      = 0;
         m_otrip       = 4'h0;
         ov_hist.delete();
         ov_hist.push_back(1'b0);
         ov_hist.push_back(1'b0);
      end else begin
         bit ov_s;
         bit trip;
         bit hold_flag;
         ov_s = ov_hist.pop_front();
         ov_hist.push_back(ovout);
         trip      = 1'b0;
         hold_flag = m_tripped && ov_s;
         if (!ena) begin
            m_powered     = 1'b0;
            m_tripped     = 1'b0;
            m_settle_left = 0;
            m_streak      = 0;
         end else if (cfg_load || !m_powered) begin
            m_powered     = 1'b1;
            m_tripped     = 1'b0;
            m_settle_left = SETTLE;
            m_streak      = 0;
         end else if (m_settle_left > 0) begin
            m_settle_left = m_settle_left - 1;
            m_streak      = 0;
         end else if (!m_tripped) begin
            if (ov_s) begin
               m_streak = m_streak + 1;
               if (m_streak == DEBOUNCE) begin
                  m_tripped = 1'b1;
                  trip      = 1'b1;
               end
            end else begin
               m_streak = 0;
            end
         end else if (clr && !ov_s) begin
            m_tripped = 1'b0;
            m_streak  = 0;
         end
         m_irq = trip;
         if (trip) m_flag = 1'b1;
         else if (clr && !hold_flag) m_flag = 1'b0;
         if (cfg_load) m_otrip = otrip_req;
      end
   end

   // Compare process: every cycle, shortly after the active edge.
   always @(posedge clk) begin
      #1;
      check("cmp_otrip",   otrip,   m_otrip);
      check("cmp_ana_ena", ana_ena, m_powered);
      check("cmp_ready",   ready,   m_powered && m_settle_left == 0 && !m_tripped);
      check("cmp_ov_flag", ov_flag, m_flag);
      check("cmp_ov_irq",  ov_irq,  m_irq);
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Raises ena and returns the number of cycles until ready (bounded).
   task automatic power_up(input string tag, output int n);
      ena = 1'b1;
      tick();
      n = 1;
      check({tag, "_ana_ena"}, ana_ena, 1'b1);
      while (!ready && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int run;
      rst_n     = 1'b1;
      ena       = 1'b0;
      otrip_req = 4'h0;
      cfg_load  = 1'b0;
      ovout     = 1'b0;
      clr       = 1'b0;
      #1 rst_n  = 1'b0;
      repeat (3) tick();
      check("rst_otrip",   otrip,   4'h0);
      check("rst_ana_ena", ana_ena, 1'b0);
      check("rst_ready",   ready,   1'b0);
      check("rst_ov_flag", ov_flag, 1'b0);
      check("rst_ov_irq",  ov_irq,  1'b0);
      rst_n = 1'b1;
      tick();

      // Power-up: ready 65 cycles after ena.
      power_up("pwr", n);
      check("pwr_ready_latency", n, 65);
      check("pwr_otrip", otrip, 4'h0);

      // 7-cycle glitch is filtered.
      ovout = 1'b1;
      repeat (7) tick();
      ovout = 1'b0;
      repeat (12) tick();
      check("glitch_ov_flag", ov_flag, 1'b0);
      check("glitch_ready", ready, 1'b1);

      // Sustained high trips 10 cycles after the rise.
      ovout = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!ov_flag && n < 50);
      check("trip_latency", n, 10);
      check("trip_irq", ov_irq, 1'b1);
      tick();
      check("trip_irq_single", ov_irq, 1'b0);
      check("trip_flag_held", ov_flag, 1'b1);
      check("trip_ready_low", ready, 1'b0);

      // clr while comparator still high is refused.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_high_flag", ov_flag, 1'b1);
      check("clr_high_ready", ready, 1'b0);

      // clr with comparator low returns to monitoring.
      ovout = 1'b0;
      repeat (3) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_low_flag", ov_flag, 1'b0);
      check("clr_low_ready", ready, 1'b1);

      // Reconfiguration, comparator high throughout settle.
      otrip_req = 4'b1010;
      cfg_load  = 1'b1;
      ovout     = 1'b1;
      tick();
      cfg_load = 1'b0;
      check("cfg_otrip", otrip, 4'b1010);
      check("cfg_ready_drop", ready, 1'b0);
      n = 0;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
      check("cfg_resettle", n, 64);
      check("cfg_settle_ignores_ov", ov_flag, 1'b0);
      ovout = 1'b0;
      repeat (5) tick();

      // Disable partway through settling, then a full restart.
      ena = 1'b0;
      tick();
      ena = 1'b1;
      tick();
      repeat (34) tick();
      ena = 1'b0;
      tick();
      check("dis_ana_ena", ana_ena, 1'b0);
      check("dis_ready", ready, 1'b0);
      power_up("reen", n);
      check("reen_ready_latency", n, 65);

      // Trip, then asynchronous reset mid-cycle.
      ovout = 1'b1;
      repeat (15) tick();
      check("pre_rst_flag", ov_flag, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_otrip",   otrip,   4'h0);
      check("arst_ana_ena", ana_ena, 1'b0);
      check("arst_ready",   ready,   1'b0);
      check("arst_ov_flag", ov_flag, 1'b0);
      check("arst_ov_irq",  ov_irq,  1'b0);
      ena   = 1'b0;
      ovout = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("post_rst_off", ana_ena, 1'b0);
      power_up("post_rst", n);
      check("post_rst_latency", n, 65);

      // clr on the debounce-complete edge: set wins.
      ovout = 1'b1;
      repeat (9) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("sim_clr_flag", ov_flag, 1'b1);
      check("sim_clr_irq", ov_irq, 1'b1);

      // cfg_load with ena=0: OFF, code applied, flag retained.
      otrip_req = 4'b0101;
      cfg_load  = 1'b1;
      ena       = 1'b0;
      tick();
      cfg_load = 1'b0;
      ovout    = 1'b0;
      check("sim_cfg_ana_ena", ana_ena, 1'b0);
      check("sim_cfg_ready", ready, 1'b0);
      check("sim_cfg_otrip", otrip, 4'b0101);
      check("sim_cfg_flag_kept", ov_flag, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("off_clr_flag", ov_flag, 1'b0);

      // Randomized phase, checked by the compare process.
      run = 0;
      for (int i = 0; i < 5000; i++) begin
         ena       = ($urandom_range(0, 299) != 0);
         cfg_load  = ($urandom_range(0, 199) == 0);
         otrip_req = 4'($urandom);
         clr       = ($urandom_range(0, 24) == 0);
         if (run == 0) begin
            ovout = ~ovout;
            run   = $urandom_range(1, 14);
         end else begin
            run--;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/overvoltage_seq.md
OVERVOLTAGE_SEQ -- requirements
Module: overvoltage_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 64: clock cycles the analog detector is given to settle after enable or a trip-code change (range 1..1023).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive synchronized high samples of the comparator needed to declare overvoltage (range 1..255).
REQ-003 clk  input  1  single block clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  level request to power and monitor the overvoltage detector.
REQ-006 otrip_req  input  4  requested trip-threshold code; sampled only when cfg_load=1.
REQ-007 cfg_load  input  1  single-cycle strobe; applies otrip_req.
REQ-008 ovout  input  1  raw comparator output, asynchronous to clk.
REQ-009 clr  input  1  single-cycle strobe; clears the sticky flag.
REQ-010 otrip  output  4  applied trip code, driving the 4-to-16 trip decoder.
REQ-011 ana_ena  output  1  analog detector enable.
REQ-012 ready  output  1  high only while the FSM is in MONITOR.
REQ-013 ov_flag  output  1  sticky overvoltage status.
REQ-014 ov_irq  output  1  one-cycle pulse on each new trip detection.

Function
REQ-015 ovout SHALL pass through a 2-flop synchronizer; the second-stage output ov_s is the only comparator view used by the FSM.
REQ-016 The FSM SHALL have four registered states: OFF, SETTLE, MONITOR, TRIPPED.
REQ-017 OFF: ana_ena=0. When ena=1, the FSM moves to SETTLE on the next edge and loads the settle counter with SETTLE_CYCLES.
REQ-018 SETTLE: ana_ena=1 and ov_s is ignored. The counter decrements each cycle; on the edge where it reaches 0, the FSM enters MONITOR. Time from ena rise to ready=1 is exactly SETTLE_CYCLES+1 cycles.
REQ-019 MONITOR: ready=1.
  - The debounce counter increments each cycle ov_s=1 and clears to 0 on any cycle ov_s=0.
  - When the count reaches DEBOUNCE_CYCLES, the FSM enters TRIPPED on that edge, sets ov_flag=1, and drives ov_irq=1 for exactly one cycle.
REQ-020 TRIPPED: ana_ena=1, ready=0, no further ov_irq. The FSM returns to MONITOR, with the debounce counter cleared, when clr=1 and ov_s=0 in the same cycle. If clr=1 while ov_s=1, the FSM stays in TRIPPED and ov_flag stays 1.
REQ-021 ov_flag SHALL be cleared only by clr or reset.
  - clr clears it the next cycle in any state except when a trip is set in the same cycle; a set wins over a clear.
  - The flag is retained across ena deassertion and cfg_load.
REQ-022 cfg_load=1 SHALL update otrip to otrip_req on the next edge in every state.
  - In SETTLE, MONITOR or TRIPPED, it also forces SETTLE with a reloaded settle counter and a cleared debounce counter.
  - In OFF, the FSM stays in OFF.
REQ-023 ena=0 SHALL force OFF on the next edge from any state. It clears both counters, de-asserts ana_ena and ready, and suppresses ov_irq. otrip is held.
REQ-024 Priority among simultaneous events: ena=0 first, then cfg_load, then trip detection, then clr-driven return to MONITOR.
REQ-025 Counters SHALL saturate and never wrap; the debounce counter never exceeds DEBOUNCE_CYCLES.
REQ-026 All outputs SHALL be registered; no combinational path runs from any input to any output.

Reset
REQ-027 While rst_n=0, the block SHALL hold: state OFF, otrip=4'b0000, ana_ena=0, ready=0, ov_flag=0, ov_irq=0, both synchronizer flops 0, both counters 0.
REQ-028 Reset assertion mid-operation SHALL take effect immediately (asynchronously). After rst_n rises, the block SHALL restart from OFF and require ena to be seen high on a clock edge.

Verification
REQ-029 Power-up scenario: reset, then ena=1 with defaults -> ana_ena=1 one cycle after ena; ready=1 exactly 65 cycles after ena; otrip=0.
REQ-030 Trip scenario: in MONITOR, ovout held high -> ov_flag=1 and a single ov_irq pulse 10 cycles after the ovout rise (2 synchronizer + 8 debounce). A 7-cycle ovout glitch produces no flag.
REQ-031 Clear scenario: TRIPPED with ovout high, then clr -> ov_flag stays 1 and the FSM stays in TRIPPED. ovout low then clr -> ov_flag=0 and ready=1 the next cycle.
REQ-032 Reconfiguration scenario: in MONITOR, cfg_load with otrip_req=4'b1010 -> otrip=4'b1010 the next cycle, ready drops, and ready returns 64 cycles later. ovout high during SETTLE is ignored.
REQ-033 Mid-operation disable/reset scenario: ena=0 during SETTLE at count 30 -> OFF and ana_ena=0 the next cycle; re-enable restarts the full 64-cycle settle. rst_n pulsed low in TRIPPED -> all outputs at reset values immediately.
REQ-034 Simultaneous-events scenario: clr coincident with the debounce-complete cycle -> ov_flag=1 and ov_irq pulses. cfg_load coincident with ena=0 -> OFF, with otrip updated.
